reg_bank_mp: RTL and testbench

// Parametrised multi-port register bank for the RV32I datapath; successor of the single-cycle BR bank.

---
 rtl/reg_bank_mp_pkg.sv | 36 +++
 rtl/reg_bank_mp_scoreboard.sv | 47 ++++
 rtl/reg_bank_mp.sv | 102 ++++++++++
 tb/tb_reg_bank_mp.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_mp_pkg.sv
// ============================================================================
// Module : reg_bank_mp_pkg
// Brief  : Shared defaults and RV32 register-field helpers for the bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_bank_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam int RS1_HI = 19;
  localparam int RS1_LO = 15;
  localparam int RS2_HI = 24;
  localparam int RS2_LO = 20;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 7;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } rv_regs_t;

  function automatic rv_regs_t decode_regs(input logic [31:0] instr);
    rv_regs_t f;
    f.rs1 = instr[RS1_HI:RS1_LO];
    f.rs2 = instr[RS2_HI:RS2_LO];
    f.rd  = instr[RD_HI:RD_LO];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_mp_scoreboard.sv
// ============================================================================
// Module : br_scoreboard
// Brief  : Per-register busy vector; writeback clears, issue sets (set wins).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module br_scoreboard
  import reg_bank_mp_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int NWR     = 1,
  parameter int AW      = $clog2(NREG),
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] wa_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  output logic [NREG-1:0]   busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Issue is applied after writeback so a newer producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k]) busy_d[wa_i[k*AW +: AW]] = 1'b0;
    end
    if (iss_valid_i) busy_d[iss_rd_i] = 1'b1;
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/reg_bank_mp.sv
// ============================================================================
// Module : reg_bank_mp
// Brief  : Multi-port register bank with write->read bypass and RAW scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_bank_mp
  import reg_bank_mp_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NRD*$clog2(NREG)-1:0]  rd_addr_i,
  output logic [NRD*XLEN-1:0]          rd_data_o,
  output logic [NRD-1:0]               hazard_o,
  input  logic [NWR-1:0]               we_i,
  input  logic [NWR*$clog2(NREG)-1:0]  wa_i,
  input  logic [NWR*XLEN-1:0]          wd_i,
  input  logic                         iss_valid_i,
  input  logic [$clog2(NREG)-1:0]      iss_rd_i,
  output logic [NREG-1:0]              busy_o
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] w_busy;

  // Ascending port order lets the highest-index port win on an address clash.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k] && !((ZERO_R0 != 0) && (wa_i[k*AW +: AW] == '0))) begin
        regs_d[wa_i[k*AW +: AW]] = wd_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  br_scoreboard #(
    .NREG    (NREG),
    .NWR     (NWR),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .wa_i        (wa_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .busy_o      (w_busy)
  );

  assign busy_o = w_busy;

  generate
    for (genvar j = 0; j < NRD; j++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_match;

      assign w_addr = rd_addr_i[j*AW +: AW];

      always_comb begin
        w_data  = regs_q[w_addr];
        w_match = 1'b0;
        if (BYPASS != 0) begin
          for (int k = 0; k < NWR; k++) begin
            if (we_i[k] && (wa_i[k*AW +: AW] == w_addr)) begin
              w_data  = wd_i[k*XLEN +: XLEN];
              w_match = 1'b1;
            end
          end
        end
        // r0 stays zero even when a write to it is in flight.
        if ((ZERO_R0 != 0) && (w_addr == '0)) begin
          w_data  = '0;
          w_match = 1'b0;
        end
      end

      assign rd_data_o[j*XLEN +: XLEN] = w_data;
      assign hazard_o[j]               = w_busy[w_addr] && !w_match;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_mp.sv
// ============================================================================
// Module : tb_reg_bank_mp
// Brief  : Self-checking bench, bypass and non-bypass banks on shared stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NRD*AW-1:0]    rd_addr = '0;
  logic [NWR-1:0]       we = '0;
  logic [NWR*AW-1:0]    wa = '0;
  logic [NWR*XLEN-1:0]  wd = '0;
  logic                 iss_valid = 1'b0;
  logic [AW-1:0]        iss_rd = '0;

  logic [NRD*XLEN-1:0]  rd_data_b, rd_data_n;
  logic [NRD-1:0]       hazard_b, hazard_n;
  logic [NREG-1:0]      busy_b, busy_n;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  always #5 clk = ~clk;

  reg_bank_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_R0(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .hazard_o(hazard_b),
    .we_i(we), .wa_i(wa), .wd_i(wd), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .busy_o(busy_b));

  reg_bank_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_R0(1)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .hazard_o(hazard_n),
    .we_i(we), .wa_i(wa), .wd_i(wd), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .busy_o(busy_n));

  // Reference model: architectural register file and outstanding-write set.
  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < NWR; k++) begin
      int a;
      a = int'(wa[k*AW +: AW]);
      if (we[k]) begin
        if (a != 0) m_regs[a] = wd[k*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a, input bit byp);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (byp)
      for (int k = 0; k < NWR; k++)
        if (we[k] && int'(wa[k*AW +: AW]) == a) v = wd[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic bit exp_hazard(input int a, input bit byp);
    bit m;
    m = 1'b0;
    if (byp && a != 0)
      for (int k = 0; k < NWR; k++)
        if (we[k] && int'(wa[k*AW +: AW]) == a) m = 1'b1;
    return m_busy[a] && !m;
  endfunction

  function automatic logic [NREG-1:0] exp_busy();
    logic [NREG-1:0] b;
    for (int r = 0; r < NREG; r++) b[r] = m_busy[r];
    return b;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst) model_clear();
    else     model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  task automatic test_reset();
    model_clear();
    cycle(); cycle();
    checks++;
    if (busy_b !== '0 || rd_data_b !== '0 || hazard_b !== '0) begin
      failures++;
      $display("FAIL reset_initial busy=%h rd=%h hz=%b want 0", busy_b, rd_data_b, hazard_b);
    end
    rst = 1'b0;
    we = 2'b01; wa = 10'd5; wd = {32'h0, 32'hDEADBEEF};
    iss_valid = 1'b1; iss_rd = 5'd12;
    cycle();
    idle_inputs();
    rd_addr = '0; rd_addr[0 +: AW] = 5'd5;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF || busy_b !== 32'h0000_1000) begin
      failures++;
      $display("FAIL reset_prewrite rd=%h busy=%h want deadbeef/00001000", rd_data_b[31:0], busy_b);
    end
    #1 rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0 || busy_b !== '0 || hazard_b !== '0) begin
      failures++;
      $display("FAIL reset_async rd=%h/%h busy=%h want 0", rd_data_b[31:0], rd_data_n[31:0], busy_b);
    end
    we = 2'b01; wa = 10'd6; wd = {32'h0, 32'h55};
    cycle();
    idle_inputs();
    rst = 1'b0;
    rd_addr[0 +: AW] = 5'd6;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_ignores_write rd=%h want 0", rd_data_b[31:0]);
    end
  endtask

  task automatic test_r0();
    we = 2'b01; wa = 10'd0; wd = {32'h0, 32'hFFFFFFFF};
    iss_valid = 1'b1; iss_rd = 5'd0;
    rd_addr = '0;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL r0_bypass rd=%h/%h want 0", rd_data_b[31:0], rd_data_n[31:0]);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b !== '0 || busy_b[0] !== 1'b0 || hazard_b !== '0) begin
      failures++;
      $display("FAIL r0_after rd=%h busy0=%b hz=%b want 0", rd_data_b, busy_b[0], hazard_b);
    end
  endtask

  task automatic test_bypass();
    we = 2'b01; wa = 10'd7; wd = {32'h0, 32'h12345678};
    rd_addr = '0; rd_addr[0 +: AW] = 5'd7;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h12345678 || rd_data_n[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL bypass_same_cycle byp=%h nobyp=%h want 12345678/00000000",
               rd_data_b[31:0], rd_data_n[31:0]);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h12345678 || rd_data_n[31:0] !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_after_edge byp=%h nobyp=%h want 12345678", rd_data_b[31:0], rd_data_n[31:0]);
    end
  endtask

  task automatic test_dual_write();
    we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'h2, 32'h1};
    rd_addr = '0; rd_addr[0 +: AW] = 5'd3; rd_addr[AW +: AW] = 5'd3;
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h2 || rd_data_b[63:32] !== 32'h2 || rd_data_n[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL dual_bypass rd0=%h rd1=%h nb=%h want 2/2/0",
               rd_data_b[31:0], rd_data_b[63:32], rd_data_n[31:0]);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (rd_data_b[31:0] !== 32'h2 || rd_data_n[31:0] !== 32'h2) begin
      failures++;
      $display("FAIL dual_priority r3=%h/%h want 2", rd_data_b[31:0], rd_data_n[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    idle_inputs();
    rd_addr = '0; rd_addr[0 +: AW] = 5'd9;
    #1;
    checks++;
    if (busy_b[9] !== 1'b1 || hazard_b[0] !== 1'b1 || hazard_n[0] !== 1'b1) begin
      failures++;
      $display("FAIL sb_issue busy9=%b hz=%b/%b want 1", busy_b[9], hazard_b[0], hazard_n[0]);
    end
    we = 2'b01; wa = 10'd9; wd = {32'h0, 32'hA5A5_0009};
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    checks++;
    if (hazard_b[0] !== 1'b0 || hazard_n[0] !== 1'b1 || rd_data_b[31:0] !== 32'hA5A5_0009) begin
      failures++;
      $display("FAIL sb_bypass_hazard hz=%b/%b rd=%h want 0/1/a5a50009",
               hazard_b[0], hazard_n[0], rd_data_b[31:0]);
    end
    cycle();
    iss_valid = 1'b0;
    wd = {32'h0, 32'h0000_0BAD};
    #1;
    checks++;
    if (busy_b[9] !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_over_clear busy9=%b want 1", busy_b[9]);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (busy_b[9] !== 1'b0 || hazard_b[0] !== 1'b0 || rd_data_n[31:0] !== 32'h0000_0BAD) begin
      failures++;
      $display("FAIL sb_clear busy9=%b hz=%b rd=%h want 0/0/00000bad", busy_b[9], hazard_b[0], rd_data_n[31:0]);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NWR; k++) begin
        we[k] = ($urandom_range(0, 99) < 40);
        wa[k*AW +: AW] = AW'($urandom_range(0, (i % 4 == 0) ? 3 : NREG - 1));
        wd[k*XLEN +: XLEN] = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 45);
      iss_rd = AW'($urandom_range(0, NREG - 1));
      for (int j = 0; j < NRD; j++)
        rd_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? wa[($urandom_range(0, NWR - 1))*AW +: AW]
                                                           : AW'($urandom_range(0, NREG - 1));
      #1;
      for (int j = 0; j < NRD; j++) begin
        int a;
        a = int'(rd_addr[j*AW +: AW]);
        checks++;
        if (rd_data_b[j*XLEN +: XLEN] !== exp_data(a, 1'b1) ||
            rd_data_n[j*XLEN +: XLEN] !== exp_data(a, 1'b0) ||
            hazard_b[j] !== exp_hazard(a, 1'b1) || hazard_n[j] !== exp_hazard(a, 1'b0)) begin
          failures++;
          $display("FAIL rand_port%0d it=%0d a=%0d got %h/%h hz %b/%b want %h/%h hz %b/%b",
                   j, i, a, rd_data_b[j*XLEN +: XLEN], rd_data_n[j*XLEN +: XLEN], hazard_b[j], hazard_n[j],
                   exp_data(a, 1'b1), exp_data(a, 1'b0), exp_hazard(a, 1'b1), exp_hazard(a, 1'b0));
        end
      end
      checks++;
      if (busy_b !== exp_busy() || busy_n !== exp_busy()) begin
        failures++;
        $display("FAIL rand_busy it=%0d got %h/%h want %h", i, busy_b, busy_n, exp_busy());
      end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_r0();
    test_bypass();
    test_dual_write();
    test_scoreboard();
    test_random(10000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
